// File: rtl/counter_pkg.sv
// Shared definitions for the modulo-N up/down counter.
// Holds the direction encodings and the check used to reject an
// illegal WIDTH/MODULUS combination at elaboration.
package counter_pkg;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    // A count sequence needs at least two states and must fit in the register.
    function automatic bit modulus_is_legal(input int width, input longint modulus);
        if (width < 1 || width > 31) begin
            return 1'b0;
        end
        return (modulus >= 2) && (modulus <= (longint'(1) << width));
    endfunction

endpackage

// File: rtl/counter_next_state.sv
// Combinational next-count logic for the modulo-N up/down counter.
// Priority is load, then enable, then hold. Out-of-range load values are
// clamped to MODULUS-1 so the count never leaves 0..MODULUS-1.
// Build option: define COUNTER_SATURATE_EN to stop at the ends of the
// range instead of wrapping.
module counter_next_state
    import counter_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 10
) (
    input  logic [WIDTH-1:0] signal_q,
    input  logic             load,
    input  logic             enable,
    input  logic             up_down,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] next_count
);

    // MODULUS may equal 2**WIDTH, so compare against it one bit wider.
    localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);
    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);

`ifdef COUNTER_SATURATE_EN
    localparam logic [WIDTH-1:0] AFTER_TOP    = MAX_VAL;
    localparam logic [WIDTH-1:0] AFTER_BOTTOM = '0;
`else
    localparam logic [WIDTH-1:0] AFTER_TOP    = '0;
    localparam logic [WIDTH-1:0] AFTER_BOTTOM = MAX_VAL;
`endif

    logic [WIDTH-1:0] load_value;

    assign load_value = ({1'b0, data_in} < MOD_EXT) ? data_in : MAX_VAL;

    // Select load, step up, step down or hold for the coming edge.
    always_comb begin
        next_count = signal_q;
        if (load) begin
            next_count = load_value;
        end else if (enable) begin
            if (up_down == DIR_UP) begin
                if (signal_q == MAX_VAL) begin
                    next_count = AFTER_TOP;
                end else begin
                    next_count = signal_q + WIDTH'(1);
                end
            end else begin
                if (signal_q == '0) begin
                    next_count = AFTER_BOTTOM;
                end else begin
                    next_count = signal_q - WIDTH'(1);
                end
            end
        end
    end

endmodule

// File: rtl/counter_modulo_n_updown.sv
// Modulo-N up/down counter with synchronous parallel load, complemented
// output and a combinational cascade terminal count.
// Build option: COUNTER_SATURATE_EN (saturate instead of wrap; terminal
// count behaviour is the same either way).
module counter_modulo_n_updown
    import counter_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 10
) (
    input  logic             clockpulse,
    input  logic             clear_,
    input  logic             enable,
    input  logic             up_down,
    input  logic             load,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] signal_q,
    output logic [WIDTH-1:0] signal_q_,
    output logic             terminal_count
);

    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);

    if (!modulus_is_legal(WIDTH, longint'(MODULUS))) begin : g_bad_modulus
        $fatal(1, "counter_modulo_n_updown: MODULUS must be in 2..2**WIDTH");
    end

    logic [WIDTH-1:0] count_reg;
    logic [WIDTH-1:0] count_next;

    counter_next_state #(
        .WIDTH   (WIDTH),
        .MODULUS (MODULUS)
    ) u_next_state (
        .signal_q   (count_reg),
        .load       (load),
        .enable     (enable),
        .up_down    (up_down),
        .data_in    (data_in),
        .next_count (count_next)
    );

    // Count register; clear_ forces zero immediately and discards any pending update.
    always_ff @(posedge clockpulse or negedge clear_) begin
        if (!clear_) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

    assign signal_q  = count_reg;
    assign signal_q_ = ~count_reg;

    // Carry when about to step past the top, borrow when about to step below zero.
    assign terminal_count = enable & ~load &
                            (((up_down == DIR_UP)   & (count_reg == MAX_VAL)) |
                             ((up_down == DIR_DOWN) & (count_reg == '0)));

endmodule

// File: tb/tb_counter_modulo_n_updown.sv
// Self-checking bench for counter_modulo_n_updown (WIDTH=4, MODULUS=10).
// Vectors are applied one per clock; the expected count is queued when the
// inputs are driven and checked after the edge that samples them.
module tb_counter_modulo_n_updown;

    typedef struct {
        logic       ld;
        logic       en;
        logic       ud;
        logic [3:0] din;
        logic       exp_tc;
        logic [3:0] exp_q;
    } vec_t;

    logic       clk;
    logic       clear_;
    logic       enable;
    logic       up_down;
    logic       load;
    logic [3:0] data_in;
    logic [3:0] signal_q;
    logic [3:0] signal_q_;
    logic       terminal_count;

    int errors;
    int checks;

    vec_t       vecs[$];
    logic [3:0] exp_fifo[$];

    counter_modulo_n_updown #(
        .WIDTH   (4),
        .MODULUS (10)
    ) dut (
        .clockpulse     (clk),
        .clear_         (clear_),
        .enable         (enable),
        .up_down        (up_down),
        .load           (load),
        .data_in        (data_in),
        .signal_q       (signal_q),
        .signal_q_      (signal_q_),
        .terminal_count (terminal_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic ld, input logic en, input logic ud, input logic [3:0] din,
                       input logic exp_tc, input logic [3:0] exp_q);
        vec_t v;
        v.ld = ld; v.en = en; v.ud = ud; v.din = din; v.exp_tc = exp_tc; v.exp_q = exp_q;
        vecs.push_back(v);
    endtask

    // Drive one vector between edges, check terminal_count, then the registered result.
    task automatic apply(input vec_t v, input string tag);
        logic [3:0] exp_q;
        @(negedge clk);
        load = v.ld; enable = v.en; up_down = v.ud; data_in = v.din;
        #1;
        check({tag, " terminal_count"}, {31'd0, terminal_count}, {31'd0, v.exp_tc});
        exp_fifo.push_back(v.exp_q);
        @(posedge clk);
        #1;
        exp_q = exp_fifo.pop_front();
        check({tag, " signal_q"}, {28'd0, signal_q}, {28'd0, exp_q});
        check({tag, " signal_q_"}, {28'd0, signal_q_}, {28'd0, ~exp_q});
        $display("%s: ld=%0b en=%0b ud=%0b din=%0d tc=%0b q=%0d (exp tc=%0b q=%0d)",
                 tag, v.ld, v.en, v.ud, v.din, terminal_count, signal_q, v.exp_tc, exp_q);
    endtask

    task automatic run_vecs(input string tag);
        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i], $sformatf("%s[%0d]", tag, i));
        end
        vecs.delete();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        errors  = 0;
        checks  = 0;
        clear_  = 1'b0;
        enable  = 1'b0;
        up_down = 1'b1;
        load    = 1'b0;
        data_in = 4'd0;

        #1;
        check("reset signal_q", {28'd0, signal_q}, 32'd0);
        check("reset signal_q_", {28'd0, signal_q_}, 32'hF);
        repeat (2) @(posedge clk);
        #1;
        check("reset held signal_q", {28'd0, signal_q}, 32'd0);
        @(negedge clk);
        clear_ = 1'b1;

`ifndef COUNTER_SATURATE_EN
        // Up-count with wrap: 1..9,0,1,2; carry only while at 9.
        for (int i = 1; i <= 12; i++) begin
            add(1'b0, 1'b1, 1'b1, 4'd0, (i == 10) ? 1'b1 : 1'b0, 4'(i % 10));
        end
        run_vecs("up");

        // Down-count with wrap from 0: 9,8,7; borrow while at 0.
        add(1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 4'd0);
        add(1'b0, 1'b1, 1'b0, 4'd0, 1'b1, 4'd9);
        add(1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 4'd8);
        add(1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 4'd7);
        run_vecs("down");

        // Loads, clamping and load suppressing terminal_count.
        add(1'b1, 1'b1, 1'b1, 4'd6,  1'b0, 4'd6);
        add(1'b1, 1'b0, 1'b1, 4'd13, 1'b0, 4'd9);
        add(1'b1, 1'b1, 1'b1, 4'd2,  1'b0, 4'd2);
        add(1'b1, 1'b0, 1'b0, 4'd10, 1'b0, 4'd9);
        add(1'b1, 1'b1, 1'b0, 4'd15, 1'b0, 4'd9);
        add(1'b1, 1'b0, 1'b0, 4'd9,  1'b0, 4'd9);
        // enable=0 at 9 going up: no carry, hold.
        add(1'b0, 1'b0, 1'b1, 4'd0,  1'b0, 4'd9);
        add(1'b1, 1'b0, 1'b0, 4'd5,  1'b0, 4'd5);
        run_vecs("load");

        // Hold for three edges, then reversal at 4.
        add(1'b0, 1'b0, 1'b1, 4'd3, 1'b0, 4'd5);
        add(1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 4'd5);
        add(1'b0, 1'b0, 1'b1, 4'd7, 1'b0, 4'd5);
        add(1'b1, 1'b0, 1'b1, 4'd3, 1'b0, 4'd3);
        add(1'b0, 1'b1, 1'b1, 4'd0, 1'b0, 4'd4);
        add(1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 4'd3);
        add(1'b0, 1'b1, 1'b1, 4'd0, 1'b0, 4'd4);
        run_vecs("hold_rev");
`else
        // Saturation: up from 8 stays at 9, down from 1 stays at 0.
        add(1'b1, 1'b0, 1'b1, 4'd8, 1'b0, 4'd8);
        add(1'b0, 1'b1, 1'b1, 4'd0, 1'b0, 4'd9);
        add(1'b0, 1'b1, 1'b1, 4'd0, 1'b1, 4'd9);
        add(1'b0, 1'b1, 1'b1, 4'd0, 1'b1, 4'd9);
        add(1'b1, 1'b0, 1'b0, 4'd1, 1'b0, 4'd1);
        add(1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 4'd0);
        add(1'b0, 1'b1, 1'b0, 4'd0, 1'b1, 4'd0);
        run_vecs("sat");
`endif

        // Asynchronous clear mid-count at 7, between edges.
        add(1'b1, 1'b0, 1'b1, 4'd7, 1'b0, 4'd7);
        run_vecs("preclr");
        @(negedge clk);
        load = 1'b0; enable = 1'b1; up_down = 1'b1;
        #2;
        clear_ = 1'b0;
        #1;
        check("async clear signal_q", {28'd0, signal_q}, 32'd0);
        check("async clear signal_q_", {28'd0, signal_q_}, 32'hF);
        $display("clear: q=%0d q_=%0h (exp 0 f)", signal_q, signal_q_);
        @(posedge clk);
        #1;
        check("clear held over edge", {28'd0, signal_q}, 32'd0);
        @(negedge clk);
        clear_ = 1'b1;
        @(posedge clk);
        #1;
        check("first count after clear", {28'd0, signal_q}, 32'd1);
        $display("release: q=%0d (exp 1)", signal_q);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/counter_modulo_n_updown.md
COUNTER_MODULO_N_UPDOWN -- requirements
Module: counter_modulo_n_updown

Interface
REQ-001 SHALL have parameter WIDTH, default 4, giving the count register width in bits.
REQ-002 SHALL have parameter MODULUS, default 10, giving the count sequence length; legal range 2..2**WIDTH.
REQ-003 SHALL have port clockpulse  input  1  single clock; all state changes on the rising edge.
REQ-004 SHALL have port clear_  input  1  asynchronous active-low reset.
REQ-005 SHALL have port enable  input  1  count enable.
REQ-006 SHALL have port up_down  input  1  direction: 1 counts up, 0 counts down.
REQ-007 SHALL have port load  input  1  synchronous parallel load strobe.
REQ-008 SHALL have port data_in  input  WIDTH  parallel load value.
REQ-009 SHALL have port signal_q  output  WIDTH  registered count value.
REQ-010 SHALL have port signal_q_  output  WIDTH  bitwise complement of signal_q, at all times.
REQ-011 SHALL have port terminal_count  output  1  cascade carry/borrow, combinational.

Function
REQ-012 SHALL apply per-edge priority: load, then enable, then hold.
REQ-013 SHALL, when load=1, register data_in if data_in < MODULUS, and MODULUS-1 otherwise; enable and up_down are ignored.
REQ-014 SHALL, when load=0 and enable=1 and up_down=1, register signal_q+1, or 0 when signal_q = MODULUS-1.
REQ-015 SHALL, when load=0 and enable=1 and up_down=0, register signal_q-1, or MODULUS-1 when signal_q = 0.
REQ-016 SHALL hold signal_q when load=0 and enable=0.
REQ-017 SHALL assert terminal_count = enable & ~load & ((up_down & signal_q==MODULUS-1) | (~up_down & signal_q==0)).
REQ-018 SHALL keep signal_q in 0..MODULUS-1 in every cycle after reset.
REQ-019 SHALL have one-edge latency: each count or load is visible on signal_q after the edge that samples it.
REQ-020 SHALL take a direction change effective at the same edge, with no extra step and no skipped value.
REQ-021 SHALL reject MODULUS outside 2..2**WIDTH at elaboration with a fatal error.

Reset
REQ-022 SHALL drive signal_q=0 and signal_q_=all-ones immediately when clear_=0, independent of clockpulse.
REQ-023 SHALL hold reset values while clear_=0 and resume counting on the first rising edge after clear_ rises.
REQ-024 SHALL abort any load or count in progress when clear_ falls; no partial update survives.

Configuration
REQ-025 SHALL, with macro COUNTER_SATURATE_EN defined, saturate rather than wrap: up holds at MODULUS-1, down holds at 0, and terminal_count is unchanged.
REQ-026 SHALL, without COUNTER_SATURATE_EN, wrap as in REQ-014/REQ-015.

Structure
REQ-027 SHALL place the direction encodings (DIR_UP=1, DIR_DOWN=0) and the parameter-legality function in shared package counter_pkg.
REQ-028 SHALL compute the next-state value in combinational sub-module counter_next_state (inputs: signal_q, load, enable, up_down, data_in; output: next count); the top holds the register, complement and terminal_count.

Verification (WIDTH=4, MODULUS=10)
REQ-029 SHALL verify reset: clear_=0 mid-count at signal_q=7, between edges -> signal_q=0 and signal_q_=4'hF at once, with no edge required.
REQ-030 SHALL verify up-count wrap: enable=1, up_down=1, 12 edges from 0 -> 1..9,0,1,2; terminal_count=1 only while signal_q=9.
REQ-031 SHALL verify down-count wrap: enable=1, up_down=0 from 0 -> 9,8,7; terminal_count=1 while signal_q=0.
REQ-032 SHALL verify load: load=1 with data_in=6 and enable=1 -> signal_q=6; load with data_in=13 -> signal_q=9; load=1 with signal_q=9 and up_down=1 -> terminal_count=0.
REQ-033 SHALL verify hold and reversal: enable=0 for 3 edges -> signal_q unchanged; at signal_q=4, flip up_down between edges -> next value 3.
REQ-034 SHALL verify saturation: with COUNTER_SATURATE_EN, up from 8 over 3 edges -> 9,9,9; down from 1 -> 0,0.
